// File: rtl/join_collector_pkg.sv
// join_collector_pkg
//   Shared types for the join side of a fork group.
//   join_mode_e : how the parent is released (all branches, any branch, none)
//   state_e     : collector FSM states
//   decode_mode : maps the raw 2-bit mode to a legal join_mode_e
//                 (code 3 is reserved and behaves as JOIN)
package join_collector_pkg;

   typedef enum logic [1:0] {
      JOIN      = 2'd0,
      JOIN_ANY  = 2'd1,
      JOIN_NONE = 2'd2
   } join_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RUN  = 2'd2
   } state_e;

   function automatic join_mode_e decode_mode(input logic [1:0] raw);
      join_mode_e m;
      case (raw)
         2'd1:    m = JOIN_ANY;
         2'd2:    m = JOIN_NONE;
         default: m = JOIN;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/join_collector_first_set_enc.sv
// first_set_enc
//   Lowest-set-bit encoder, purely combinational.
//   Ports:
//     vec   in  N  input vector
//     idx   out W  index of the lowest set bit (0 when vec is zero)
//     valid out 1  vec has at least one bit set
module first_set_enc
   import join_collector_pkg::*;
#(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         valid
);

   // Scan from the top down so the last hit (the lowest bit) wins.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
   end

   assign valid = |vec;

endmodule

// File: rtl/join_collector.sv
// join_collector
//   Join side of a fork: collects per-branch done pulses, releases the parent
//   with a resume pulse according to the join mode, and while the parent runs
//   ahead of pending branches forwards its event triggers to them.
//
//   Optional feature: define JOIN_COLLECTOR_TIMEOUT_EN to enable a WAIT-state
//   timeout counter (tmo_limit cycles, 0 disables). Without the macro the
//   counter is absent, tmo_limit is unused and timeout is tied to 0.
//
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   synchronous active-high reset
//     fork_start  in   pulse opening a fork group
//     join_mode   in   2  join mode sampled with fork_start
//     branch_done in   N_BRANCH per-branch completion pulses
//     cont_req    in   parent event trigger
//     tmo_limit   in   TMO_W  WAIT timeout limit (macro only)
//     busy        out  fork group open
//     resume      out  one-cycle parent release pulse
//     any_idx     out  index of the first finisher of the group
//     done_mask   out  branches completed in the current group
//     cont_evt    out  one-cycle event pulses to pending branches
//     err         out  fork_start received while busy
//     timeout     out  WAIT timeout expired (macro only)
module join_collector
   import join_collector_pkg::*;
#(
   parameter int N_BRANCH = 2,
   parameter int TMO_W    = 16,
   localparam int IDX_W   = (N_BRANCH > 1) ? $clog2(N_BRANCH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                fork_start,
   input  logic [1:0]          join_mode,
   input  logic [N_BRANCH-1:0] branch_done,
   input  logic                cont_req,
   input  logic [TMO_W-1:0]    tmo_limit,
   output logic                busy,
   output logic                resume,
   output logic [IDX_W-1:0]    any_idx,
   output logic [N_BRANCH-1:0] done_mask,
   output logic [N_BRANCH-1:0] cont_evt,
   output logic                err,
   output logic                timeout
);

   localparam logic [N_BRANCH-1:0] ALL_DONE = '1;

   state_e              state_reg, state_next;
   join_mode_e          mode_reg, mode_next;
   logic [N_BRANCH-1:0] mask_reg, mask_next, mask_upd;
   logic [IDX_W-1:0]    idx_reg, idx_next;
   logic                seen_reg, seen_next;
   logic                busy_reg;
   logic                resume_reg, resume_next;
   logic [N_BRANCH-1:0] cevt_reg, cevt_next;
   logic                err_reg, err_next;
   logic                tmo_reg, tmo_next;
   logic                cond_met;

   logic [IDX_W-1:0]    enc_idx;
   logic                enc_valid;

   first_set_enc #(
      .N (N_BRANCH),
      .W (IDX_W)
   ) u_first_set_enc (
      .vec   (branch_done),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

`ifdef JOIN_COLLECTOR_TIMEOUT_EN
   logic [TMO_W-1:0] cnt_reg, cnt_next;
`else
   logic unused_tmo_limit;
   assign unused_tmo_limit = ^tmo_limit;
`endif

   assign mask_upd = mask_reg | branch_done;
   assign cond_met = (mode_reg == JOIN_ANY) ? (|mask_upd) : (mask_upd == ALL_DONE);

   always_comb begin
      state_next  = state_reg;
      mode_next   = mode_reg;
      mask_next   = mask_reg;
      idx_next    = idx_reg;
      seen_next   = seen_reg;
      resume_next = 1'b0;
      cevt_next   = '0;
      err_next    = 1'b0;
      tmo_next    = 1'b0;
`ifdef JOIN_COLLECTOR_TIMEOUT_EN
      cnt_next    = cnt_reg;
`endif

      // Common to WAIT and RUN: accumulate dones, latch the first finisher
      // once per group, and flag a fork_start that arrives while open.
      if (state_reg != IDLE) begin
         mask_next = mask_upd;
         if (!seen_reg && enc_valid) begin
            idx_next  = enc_idx;
            seen_next = 1'b1;
         end
         if (fork_start) begin
            err_next = 1'b1;
         end
      end

      case (state_reg)
         IDLE: begin
            // branch_done in the fork_start cycle is deliberately not merged.
            if (fork_start) begin
               mask_next = '0;
               idx_next  = '0;
               seen_next = 1'b0;
               mode_next = decode_mode(join_mode);
`ifdef JOIN_COLLECTOR_TIMEOUT_EN
               cnt_next  = '0;
`endif
               if (decode_mode(join_mode) == JOIN_NONE) begin
                  resume_next = 1'b1;
                  state_next  = RUN;
               end else begin
                  state_next  = WAIT;
               end
            end
         end

         WAIT: begin
            // cont_req is dropped here: the parent is blocked.
            if (cond_met) begin
               resume_next = 1'b1;
               state_next  = (mask_upd == ALL_DONE) ? IDLE : RUN;
            end
`ifdef JOIN_COLLECTOR_TIMEOUT_EN
            else begin
               cnt_next = cnt_reg + 1'b1;
               if ((tmo_limit != '0) && (cnt_next == tmo_limit)) begin
                  resume_next = 1'b1;
                  tmo_next    = 1'b1;
                  state_next  = (mask_upd == ALL_DONE) ? IDLE : RUN;
               end
            end
`endif
         end

         RUN: begin
            // Branches finishing this very cycle receive no event.
            if (cont_req) begin
               cevt_next = ~mask_upd;
            end
            if (mask_upd == ALL_DONE) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         mode_reg   <= JOIN;
         mask_reg   <= '0;
         idx_reg    <= '0;
         seen_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         resume_reg <= 1'b0;
         cevt_reg   <= '0;
         err_reg    <= 1'b0;
         tmo_reg    <= 1'b0;
`ifdef JOIN_COLLECTOR_TIMEOUT_EN
         cnt_reg    <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         mode_reg   <= mode_next;
         mask_reg   <= mask_next;
         idx_reg    <= idx_next;
         seen_reg   <= seen_next;
         busy_reg   <= (state_next != IDLE);
         resume_reg <= resume_next;
         cevt_reg   <= cevt_next;
         err_reg    <= err_next;
         tmo_reg    <= tmo_next;
`ifdef JOIN_COLLECTOR_TIMEOUT_EN
         cnt_reg    <= cnt_next;
`endif
      end
   end

   assign busy      = busy_reg;
   assign resume    = resume_reg;
   assign any_idx   = idx_reg;
   assign done_mask = mask_reg;
   assign cont_evt  = cevt_reg;
   assign err       = err_reg;
   assign timeout   = tmo_reg;

endmodule

// File: tb/tb_join_collector.sv
// tb_join_collector
//   Table-driven check of join_collector with a 2-branch and a 4-branch
//   instance. Each row drives one cycle of inputs to the selected instance
//   and carries the outputs expected right after that clock edge.
module tb_join_collector;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // 2-branch instance
   logic        fs2, cr2;
   logic [1:0]  mode2, done2;
   logic [15:0] tmo2;
   logic        busy2, res2, err2, to2;
   logic [0:0]  idx2;
   logic [1:0]  mask2, cevt2;

   // 4-branch instance
   logic        fs4, cr4;
   logic [1:0]  mode4;
   logic [3:0]  done4;
   logic [15:0] tmo4;
   logic        busy4, res4, err4, to4;
   logic [1:0]  idx4;
   logic [3:0]  mask4, cevt4;

   join_collector #(.N_BRANCH(2), .TMO_W(16)) dut2 (
      .clk(clk), .rst(rst), .fork_start(fs2), .join_mode(mode2),
      .branch_done(done2), .cont_req(cr2), .tmo_limit(tmo2),
      .busy(busy2), .resume(res2), .any_idx(idx2), .done_mask(mask2),
      .cont_evt(cevt2), .err(err2), .timeout(to2)
   );

   join_collector #(.N_BRANCH(4), .TMO_W(16)) dut4 (
      .clk(clk), .rst(rst), .fork_start(fs4), .join_mode(mode4),
      .branch_done(done4), .cont_req(cr4), .tmo_limit(tmo4),
      .busy(busy4), .resume(res4), .any_idx(idx4), .done_mask(mask4),
      .cont_evt(cevt4), .err(err4), .timeout(to4)
   );

   typedef struct {
      logic        rst;
      logic        sel4;
      logic        fs;
      logic [1:0]  mode;
      logic [3:0]  done;
      logic        cr;
      logic [15:0] tmo;
      logic        e_busy;
      logic        e_res;
      logic [1:0]  e_idx;
      logic [3:0]  e_mask;
      logic [3:0]  e_cevt;
      logic        e_err;
      logic        e_to;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic r, input logic s4, input logic fs,
                               input logic [1:0] m, input logic [3:0] d,
                               input logic cr, input logic [15:0] tmo,
                               input logic eb, input logic er,
                               input logic [1:0] ei, input logic [3:0] em,
                               input logic [3:0] ec, input logic ee,
                               input logic et);
      vec_t v;
      v.rst = r; v.sel4 = s4; v.fs = fs; v.mode = m; v.done = d; v.cr = cr;
      v.tmo = tmo; v.e_busy = eb; v.e_res = er; v.e_idx = ei; v.e_mask = em;
      v.e_cevt = ec; v.e_err = ee; v.e_to = et;
      return v;
   endfunction

   task automatic chk(input string nm, input int row,
                      input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int row);
      vec_t e;
      @(negedge clk);
      rst   = v.rst;
      fs2   = v.sel4 ? 1'b0 : v.fs;
      mode2 = v.mode;
      done2 = v.sel4 ? 2'b00 : v.done[1:0];
      cr2   = v.sel4 ? 1'b0 : v.cr;
      tmo2  = v.sel4 ? 16'd0 : v.tmo;
      fs4   = v.sel4 ? v.fs : 1'b0;
      mode4 = v.mode;
      done4 = v.sel4 ? v.done : 4'b0000;
      cr4   = v.sel4 ? v.cr : 1'b0;
      tmo4  = v.sel4 ? v.tmo : 16'd0;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.sel4) begin
         chk("busy",      row, {3'b0, busy4}, {3'b0, e.e_busy});
         chk("resume",    row, {3'b0, res4},  {3'b0, e.e_res});
         chk("any_idx",   row, {2'b0, idx4},  {2'b0, e.e_idx});
         chk("done_mask", row, mask4,         e.e_mask);
         chk("cont_evt",  row, cevt4,         e.e_cevt);
         chk("err",       row, {3'b0, err4},  {3'b0, e.e_err});
         chk("timeout",   row, {3'b0, to4},   {3'b0, e.e_to});
         $display("txn %0d n=4 fs=%0b done=%b cr=%0b -> busy=%0b res=%0b idx=%0d mask=%b cevt=%b err=%0b to=%0b",
                  row, e.fs, e.done, e.cr, busy4, res4, idx4, mask4, cevt4, err4, to4);
      end else begin
         chk("busy",      row, {3'b0, busy2}, {3'b0, e.e_busy});
         chk("resume",    row, {3'b0, res2},  {3'b0, e.e_res});
         chk("any_idx",   row, {3'b0, idx2},  {2'b0, e.e_idx});
         chk("done_mask", row, {2'b0, mask2}, e.e_mask);
         chk("cont_evt",  row, {2'b0, cevt2}, e.e_cevt);
         chk("err",       row, {3'b0, err2},  {3'b0, e.e_err});
         chk("timeout",   row, {3'b0, to2},   {3'b0, e.e_to});
         $display("txn %0d n=2 rst=%0b fs=%0b done=%b cr=%0b -> busy=%0b res=%0b idx=%0d mask=%b cevt=%b err=%0b to=%0b",
                  row, e.rst, e.fs, e.done[1:0], e.cr, busy2, res2, idx2, mask2, cevt2, err2, to2);
      end
   endtask

   initial begin
      rst = 1'b1; fs2 = 1'b0; mode2 = 2'd0; done2 = '0; cr2 = 1'b0; tmo2 = '0;
      fs4 = 1'b0; mode4 = 2'd0; done4 = '0; cr4 = 1'b0; tmo4 = '0;

      //              rst s4 fs mode done    cr tmo  busy res idx mask    cevt    err to
      // reset state
      vecs.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
      // JOIN_ANY, done[0] three cycles after fork, then cont_req and done[1]
      vecs.push_back(mk(0, 0, 1, 2'd1, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0001, 0, 0, 1, 1, 0, 4'b0001, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 1, 0, 1, 0, 0, 4'b0001, 4'b0010, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0010, 1, 0, 0, 0, 0, 4'b0011, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 0, 0, 0, 0, 0, 4'b0011, 4'b0000, 0, 0));
      // JOIN_NONE, then fork_start while busy
      vecs.push_back(mk(0, 0, 1, 2'd2, 4'b0000, 0, 0, 1, 1, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 1, 2'd1, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0010, 0, 0, 1, 0, 1, 4'b0010, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 1, 0, 1, 0, 1, 4'b0010, 4'b0001, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0011, 0, 0, 0, 0, 1, 4'b0011, 4'b0000, 0, 0));
      // reserved mode 3 acts as JOIN; dones with fork_start ignored; duplicates
      vecs.push_back(mk(0, 0, 1, 2'd3, 4'b0011, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0001, 1, 0, 1, 0, 0, 4'b0001, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0001, 0, 0, 1, 0, 0, 4'b0001, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0010, 0, 0, 0, 1, 0, 4'b0011, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0010, 0, 0, 0, 0, 0, 4'b0011, 4'b0000, 0, 0));
      // back-to-back forks
      vecs.push_back(mk(0, 0, 1, 2'd0, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0011, 0, 0, 0, 1, 0, 4'b0011, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 1, 2'd1, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0001, 0, 0, 1, 1, 0, 4'b0001, 4'b0000, 0, 0));
      // reset while in RUN with done_mask=01; late done[1] ignored
      vecs.push_back(mk(1, 0, 0, 2'd0, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0010, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
      // N=4 JOIN, done order 2,0,3,1
      vecs.push_back(mk(0, 1, 1, 2'd0, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b0100, 0, 0, 1, 0, 2, 4'b0100, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b0001, 0, 0, 1, 0, 2, 4'b0101, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b1000, 0, 0, 1, 0, 2, 4'b1101, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b0010, 0, 0, 0, 1, 2, 4'b1111, 4'b0000, 0, 0));
      // N=4 JOIN_ANY, two dones in one cycle
      vecs.push_back(mk(0, 1, 1, 2'd1, 4'b0000, 0, 0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b1010, 0, 0, 1, 1, 1, 4'b1010, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b0000, 1, 0, 1, 0, 1, 4'b1010, 4'b0101, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2'd0, 4'b0101, 0, 0, 0, 0, 1, 4'b1111, 4'b0000, 0, 0));
`ifdef JOIN_COLLECTOR_TIMEOUT_EN
      // JOIN with no dones and tmo_limit=5: timeout+resume 5 cycles into WAIT
      vecs.push_back(mk(0, 0, 1, 2'd0, 4'b0000, 0, 5, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      for (int k = 0; k < 4; k++) begin
         vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 0, 5, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      end
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 0, 5, 1, 1, 0, 4'b0000, 4'b0000, 0, 1));
      // now in RUN: cont_req reaches both pending branches, then completion
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 1, 5, 1, 0, 0, 4'b0000, 4'b0011, 0, 0));
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0011, 0, 5, 0, 0, 0, 4'b0011, 4'b0000, 0, 0));
`else
      // tmo_limit has no effect without the timeout feature
      vecs.push_back(mk(0, 0, 1, 2'd0, 4'b0000, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      for (int k = 0; k < 3; k++) begin
         vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0000, 0, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
      end
      vecs.push_back(mk(0, 0, 0, 2'd0, 4'b0011, 0, 1, 0, 1, 0, 4'b0011, 4'b0000, 0, 0));
`endif

      for (int r = 0; r < vecs.size(); r++) begin
         apply(vecs[r], r);
      end

      @(negedge clk);
      fs2 = 1'b0; done2 = '0; cr2 = 1'b0; fs4 = 1'b0; done4 = '0; cr4 = 1'b0;
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/join_collector.md
# join_collector

Synthesizable completion tracker for the dynamic-scheduler test designs: the join side of a fork. After a fork is launched it collects per-branch `done` pulses and releases the parent with a `resume` pulse according to the join mode (`join`, `join_any`, `join_none`). While a parent runs ahead of still-pending branches, it forwards the parent's event triggers to those branches as `cont_evt`.

## Interface
- `N_BRANCH`, default 2: number of forked branches; at least 1.
- `TMO_W`, default 16: width of the join timeout counter (used only with the macro).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fork_start`  in  1  one-cycle pulse that opens a fork group.
- `join_mode`  in  2  sampled with `fork_start`:
  - 0: JOIN (all branches)
  - 1: JOIN_ANY
  - 2: JOIN_NONE
  - 3: reserved, treated as JOIN
- `branch_done`  in  N_BRANCH  per-branch completion pulse.
- `cont_req`  in  1  parent triggers its event (`->cont`).
- `tmo_limit`  in  TMO_W  cycles allowed in WAIT; 0 disables the timeout.
- `busy`  out  1  fork group open.
- `resume`  out  1  one-cycle pulse that releases the parent.
- `any_idx`  out  $clog2(N_BRANCH) (minimum 1)  index of the first finisher, held until the next `fork_start`.
- `done_mask`  out  N_BRANCH  branches completed in the current group.
- `cont_evt`  out  N_BRANCH  one-cycle event pulse to pending branches.
- `err`  out  1  one-cycle pulse when `fork_start` arrives while `busy`.
- `timeout`  out  1  one-cycle pulse when the timeout expires (macro only).

## Operation
- States: IDLE, WAIT, RUN.
- IDLE
  - `busy=0`; `branch_done` and `cont_req` are ignored.
  - On `fork_start`: clear `done_mask`, latch the mode.
  - JOIN or JOIN_ANY: go to WAIT.
  - JOIN_NONE: go to RUN.
- WAIT
  - OR `branch_done` into `done_mask`.
  - The condition is met when the updated mask is non-zero (ANY) or all ones (JOIN).
  - When met: pulse `resume`. Go to IDLE if the mask is all ones, otherwise to RUN.
  - `cont_req` in WAIT is dropped (parent is blocked).
- RUN
  - Keep accumulating `done_mask`.
  - `cont_req` drives `cont_evt = ~done_mask_updated`, so a branch finishing in the same cycle gets no event.
  - Go to IDLE when the mask becomes all ones.
- `any_idx`
  - Latched once per group: the lowest set bit of the first non-zero `branch_done` seen after `fork_start`.
  - Reset value 0.
- Boundary cases
  - A duplicate `done` for an already-set bit has no effect.
  - `fork_start` while `busy`: ignored, `err` pulses.
  - `branch_done` in the same cycle as `fork_start`: ignored.
  - `N_BRANCH=1`: JOIN and JOIN_ANY behave identically.
- Reset mid-operation: return to IDLE; every output and internal register goes to 0.

## Timing
- All outputs are registered.
- Reset values: `busy`, `resume`, `any_idx`, `done_mask`, `cont_evt`, `err` and `timeout` are all 0.
- `busy`: goes to 1 the cycle after `fork_start`; goes to 0 the cycle after the last completing `done`.
- JOIN / JOIN_ANY: `resume` is high the cycle after the edge that samples the completing `branch_done`.
- JOIN_NONE: `resume` is high the cycle after `fork_start`.
- `done_mask`: visible 1 cycle after the `done` edge.
- `cont_evt`: 1 cycle after `cont_req`.
- `err`: 1 cycle after the offending `fork_start`.
- Back-to-back forks: a new `fork_start` is accepted in the cycle where `busy` reads 0.

## Configuration
- Macro `JOIN_COLLECTOR_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - When it reaches a non-zero `tmo_limit`, `timeout` and `resume` pulse together.
  - Next state: RUN if any branch is pending, else IDLE.
  - If `timeout` and the completion condition hit in the same cycle, completion wins and `timeout` stays 0.
- Undefined: no counter; `tmo_limit` is unused; `timeout` is tied to 0.

## Structure
- `join_collector_pkg` holds:
  - `join_mode_e` (JOIN=0, JOIN_ANY=1, JOIN_NONE=2)
  - `state_e` (IDLE, WAIT, RUN)
- Sub-module `first_set_enc`: parameterized lowest-set-bit encoder with valid output, used for `any_idx`.

## Test plan
- N=2, JOIN_ANY, `done[0]` 3 cycles after fork → `resume` pulses once, `any_idx=0`, `busy=1`. A later `cont_req` gives `cont_evt=2'b10`. `done[1]` → `busy=0`, `done_mask=2'b11`.
- N=4, JOIN, done order 2,0,3,1 → no `resume` until `done[1]`, then `resume` one cycle later and `busy=0` in the same cycle.
- N=4, JOIN_ANY, `done=4'b1010` in a single cycle → `any_idx=1`, `resume` once.
- JOIN_NONE → `resume` the cycle after `fork_start`. Second `fork_start` while busy → `err`=1 for one cycle, mode unchanged.
- `rst` asserted while in RUN with `done_mask=2'b01` → next cycle all outputs 0, state IDLE; late `done[1]` is ignored.
- Macro defined, `tmo_limit=5`, JOIN with no dones → `timeout` and `resume` in the same cycle, 5 cycles into WAIT; state RUN.
